// File: rtl/multi_strobe_generator.sv
// Multi-channel programmable strobe generator: each channel divides clk_in by a
// runtime divisor, producing a one-cycle tick and a near-50% divided-clock level.
module multi_strobe_generator #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 4
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n,
    input  logic [NUM_CH-1:0]                     en,
    input  logic                                  sync_in,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                      cfg_div,
    output logic [NUM_CH-1:0]                     tick_out,
    output logic [NUM_CH-1:0]                     clk_out
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

    logic [NUM_CH-1:0] pend_vec;

    // Out-of-range channels are always ready so their writes drain harmlessly.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend_vec[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt, act_div, pend_div;
        logic             pend_flag, tick_r, clk_r;
        logic [CNT_W-1:0] cnt_nx, div_nx, pdiv_nx;
        logic             pflag_nx, tick_nx, clk_nx;
        logic             wr_hit, wrap;

        assign wr_hit      = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
        assign wrap        = (cnt == act_div - ONE);
        assign pend_vec[g] = pend_flag;
        assign tick_out[g] = tick_r;
        assign clk_out[g]  = clk_r;

        always_comb begin
            cnt_nx   = cnt;
            div_nx   = act_div;
            pdiv_nx  = pend_div;
            pflag_nx = pend_flag;
            tick_nx  = 1'b0;
            clk_nx   = clk_r;
            if (sync_in) begin
                cnt_nx = '0;
                if (pend_flag) begin
                    div_nx   = pend_div;
                    pflag_nx = 1'b0;
                end
                clk_nx = (div_nx >> 1) != '0;
            end else if (!en[g]) begin
                // Idle channel takes a pending divisor right away and restarts its phase.
                if (pend_flag) begin
                    div_nx   = pend_div;
                    pflag_nx = 1'b0;
                    cnt_nx   = '0;
                end
            end else if (wrap) begin
                cnt_nx  = '0;
                tick_nx = 1'b1;
                if (pend_flag) begin
                    div_nx   = pend_div;
                    pflag_nx = 1'b0;
                end
                clk_nx = (div_nx >> 1) != '0;
            end else begin
                cnt_nx = cnt + ONE;
                clk_nx = cnt_nx < (act_div >> 1);
            end
            // Ready is low while pending, so a transfer never collides with an apply.
            if (wr_hit) begin
                pdiv_nx  = (cfg_div == '0) ? ONE : cfg_div;
                pflag_nx = 1'b1;
            end
        end

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt       <= '0;
                act_div   <= DEF_VAL;
                pend_div  <= DEF_VAL;
                pend_flag <= 1'b0;
                tick_r    <= 1'b0;
                clk_r     <= 1'b0;
            end else begin
                cnt       <= cnt_nx;
                act_div   <= div_nx;
                pend_div  <= pdiv_nx;
                pend_flag <= pflag_nx;
                tick_r    <= tick_nx;
                clk_r     <= clk_nx;
            end
        end
    end

endmodule

// File: tb/tb_multi_strobe_generator.sv
// Bench for multi_strobe_generator: directed scenarios plus random traffic, all
// compared each cycle against a phase/period reference model.
module tb_multi_strobe_generator;

    localparam int NUM_CH  = 5;
    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 4;
    localparam int CH_W    = 3;

    logic              clk_in    = 1'b0;
    logic              rst_n     = 1'b0;
    logic              sync_in   = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [NUM_CH-1:0] en        = '0;
    logic [CH_W-1:0]   cfg_ch    = '0;
    logic [CNT_W-1:0]  cfg_div   = '0;
    logic              cfg_ready;
    logic [NUM_CH-1:0] tick_out;
    logic [NUM_CH-1:0] clk_out;

    int checks = 0;
    int errors = 0;

    int                m_cnt  [NUM_CH];
    int                m_div  [NUM_CH];
    int                m_pdiv [NUM_CH];
    bit                m_pend [NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_clk;

    always #5 clk_in = ~clk_in;

    multi_strobe_generator #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .sync_in  (sync_in),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .tick_out (tick_out),
        .clk_out  (clk_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int ch);
        return (ch >= NUM_CH) ? 1'b1 : !m_pend[ch];
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c]  = 0;
            m_div[c]  = DEF_DIV;
            m_pdiv[c] = DEF_DIV;
            m_pend[c] = 1'b0;
        end
        m_tick = '0;
        m_clk  = '0;
    endtask

    // Phase p runs 0..D-1; tick marks the return to 0, level is high while p < floor(D/2).
    task automatic m_step(input bit acc);
        for (int c = 0; c < NUM_CH; c++) begin : ch
            bit apply;
            apply = 1'b0;
            if (sync_in) begin
                m_cnt[c]  = 0;
                m_tick[c] = 1'b0;
                apply     = m_pend[c];
            end else if (!en[c]) begin
                m_tick[c] = 1'b0;
                if (m_pend[c]) begin
                    apply    = 1'b1;
                    m_cnt[c] = 0;
                end
            end else if (m_cnt[c] == m_div[c] - 1) begin
                m_cnt[c]  = 0;
                m_tick[c] = 1'b1;
                apply     = m_pend[c];
            end else begin
                m_cnt[c]  = m_cnt[c] + 1;
                m_tick[c] = 1'b0;
            end
            if (apply) begin
                m_div[c]  = m_pdiv[c];
                m_pend[c] = 1'b0;
            end
            if (sync_in || en[c]) m_clk[c] = (m_cnt[c] < m_div[c] / 2);
            if (acc && int'(cfg_ch) == c) begin
                m_pdiv[c] = (cfg_div == '0) ? 1 : int'(cfg_div);
                m_pend[c] = 1'b1;
            end
        end
    endtask

    // Starts and ends on a falling edge; inputs are driven between calls.
    task automatic cycle(input string tag);
        bit acc;
        #1;
        chk({tag, ".ready"}, 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
        acc = cfg_valid && m_ready(int'(cfg_ch));
        @(posedge clk_in);
        m_step(acc);
        @(negedge clk_in);
        chk({tag, ".tick"}, 32'(tick_out), 32'(m_tick));
        chk({tag, ".clk"},  32'(clk_out),  32'(m_clk));
    endtask

    initial begin
        m_reset();
        @(negedge clk_in);
        chk("rst.tick",  32'(tick_out),  32'(0));
        chk("rst.clk",   32'(clk_out),   32'(0));
        chk("rst.ready", 32'(cfg_ready), 32'(1));
        rst_n = 1'b1;

        // Channel 0 free-running at the reset divisor
        en = 5'b00001;
        for (int k = 1; k <= 12; k++) begin
            cycle("t1");
            chk("t1.tick0", 32'(tick_out[0]), 32'(k % 4 == 0));
            chk("t1.clk0",  32'(clk_out[0]),  32'((k % 4 == 0) || (k % 4 == 1)));
        end

        // Reprogram ch0 mid-period; the current period still completes at 4
        cycle("t2.pre");
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd6;
        cycle("t2.wr");
        cfg_div = 16'd7;
        #1 chk("t2.stall", 32'(cfg_ready), 32'(0));
        for (int k = 1; k <= 14; k++) begin
            cycle("t2");
            cfg_valid = 1'b0;
            chk("t2.tick0", 32'(tick_out[0]), 32'(k == 2 || k == 8 || k == 14));
            if (k >= 2) chk("t2.clk0", 32'(clk_out[0]), 32'((k - 2) % 6 < 3));
        end

        // Divisor 0 is stored as 1: tick constantly high, level constantly low
        cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd0;
        cycle("t3.wr");
        cfg_valid = 1'b0;
        cycle("t3.apply");
        en = 5'b00011;
        for (int k = 1; k <= 6; k++) begin
            cycle("t3");
            chk("t3.tick1", 32'(tick_out[1]), 32'(1));
            chk("t3.clk1",  32'(clk_out[1]),  32'(0));
        end

        // ch0 back to 4, ch2 at 5, then realign both with sync_in
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd5;
        cycle("t4.wr2");
        cfg_valid = 1'b0;
        cycle("t4.apply2");
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd4;
        cycle("t4.wr0");
        cfg_valid = 1'b0;
        en = 5'b00111;
        for (int k = 0; k < 9; k++) cycle("t4.run");
        sync_in = 1'b1;
        cycle("t4.sync");
        sync_in = 1'b0;
        chk("t4.sync_tick", 32'(tick_out), 32'(0));
        for (int k = 1; k <= 6; k++) begin
            cycle("t4");
            chk("t4.tick0", 32'(tick_out[0]), 32'(k == 4));
            chk("t4.tick2", 32'(tick_out[2]), 32'(k == 5));
        end

        // Pause ch0 at phase 2, then resume
        en = 5'b00110;
        for (int k = 0; k < 10; k++) begin
            cycle("t5.idle");
            chk("t5.idle_tick0", 32'(tick_out[0]), 32'(0));
            chk("t5.idle_clk0",  32'(clk_out[0]),  32'(0));
        end
        en = 5'b00111;
        for (int k = 1; k <= 2; k++) begin
            cycle("t5.resume");
            chk("t5.resume_tick0", 32'(tick_out[0]), 32'(k == 2));
        end
        en = 5'b00110;
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd3;
        cycle("t5.wr");
        cfg_valid = 1'b0;
        cycle("t5.apply");
        en = 5'b00111;
        for (int k = 1; k <= 3; k++) begin
            cycle("t5.new");
            chk("t5.new_tick0", 32'(tick_out[0]), 32'(k == 3));
            chk("t5.new_clk0",  32'(clk_out[0]),  32'(k == 3));
        end

        // Asynchronous reset mid-period with a write still pending on ch2
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd9;
        cycle("t6.wr");
        cfg_valid = 1'b0;
        cycle("t6.run");
        #2 rst_n = 1'b0;
        #1;
        chk("t6.rst_tick",  32'(tick_out),  32'(0));
        chk("t6.rst_clk",   32'(clk_out),   32'(0));
        chk("t6.rst_ready", 32'(cfg_ready), 32'(1));
        @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        m_reset();
        for (int k = 1; k <= 8; k++) begin
            cycle("t6.post");
            chk("t6.tick2", 32'(tick_out[2]), 32'(k % 4 == 0));
        end
        cfg_valid = 1'b1; cfg_ch = 3'(NUM_CH); cfg_div = 16'd2;
        #1 chk("t6.oor_ready", 32'(cfg_ready), 32'(1));
        cycle("t6.oor");
        cfg_valid = 1'b0;
        for (int k = 0; k < 8; k++) cycle("t6.oor_run");

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) en = NUM_CH'($urandom);
            sync_in   = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 7));
            cfg_div   = CNT_W'($urandom_range(0, 8));
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
